psum_pool_collect: RTL and testbench



---
 rtl/psum_pool_collect_pkg.sv | 17 +
 rtl/psum_pool_collect_lane.sv | 81 ++++++++
 rtl/psum_pool_collect.sv | 139 +++++++++++++
 tb/tb_psum_pool_collect.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pool_collect_pkg.sv
// Shared types and constants for the partial-sum accumulate / 2x2 max-pool collector.
package psum_pool_collect_pkg;

  localparam int unsigned PSUM_LEN_DEF    = 20;
  localparam int unsigned COM_DATALEN_DEF = 24;

  // Saturation limits of the default accumulator width.
  localparam logic signed [COM_DATALEN_DEF-1:0] SAT_MAX = {1'b0, {(COM_DATALEN_DEF-1){1'b1}}};
  localparam logic signed [COM_DATALEN_DEF-1:0] SAT_MIN = {1'b1, {(COM_DATALEN_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/psum_pool_collect_lane.sv
// One mesh lane: four saturating accumulators followed by a two-stage signed max tree.
module psum_lane
  import psum_pool_collect_pkg::*;
#(
  parameter int unsigned PSUM_LEN    = PSUM_LEN_DEF,
  parameter int unsigned COM_DATALEN = COM_DATALEN_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       acc_en,
  input  logic                       acc_load,
  input  logic                       s1_en,
  input  logic                       s2_en,
  input  logic [4*PSUM_LEN-1:0]      psum,
  output logic [4*COM_DATALEN-1:0]   quad,
  output logic [COM_DATALEN-1:0]     pool
);

  logic [3:0][COM_DATALEN-1:0] ext_d;
  logic [3:0][COM_DATALEN:0]   sum_d;
  logic [3:0][COM_DATALEN-1:0] acc_d;
  logic [3:0][COM_DATALEN-1:0] acc_q;
  logic [3:0][COM_DATALEN-1:0] s1_quad_q;
  logic [1:0][COM_DATALEN-1:0] s1_max_q;
  logic [3:0][COM_DATALEN-1:0] quad_q;
  logic [COM_DATALEN-1:0]      pool_q;

  function automatic logic [COM_DATALEN-1:0] smax(input logic [COM_DATALEN-1:0] a,
                                                  input logic [COM_DATALEN-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  // Sign-extend each element and form the clamped running sum.
  always_comb begin
    ext_d = '0;
    sum_d = '0;
    acc_d = '0;
    for (int e = 0; e < 4; e++) begin
      ext_d[e] = {{(COM_DATALEN-PSUM_LEN){psum[e*PSUM_LEN+PSUM_LEN-1]}},
                  psum[e*PSUM_LEN +: PSUM_LEN]};
      sum_d[e] = {acc_q[e][COM_DATALEN-1], acc_q[e]} + {ext_d[e][COM_DATALEN-1], ext_d[e]};
      if (acc_load) begin
        acc_d[e] = ext_d[e];
      end else if (sum_d[e][COM_DATALEN] != sum_d[e][COM_DATALEN-1]) begin
        // Overflow: clamp toward the sign of the true result.
        acc_d[e] = sum_d[e][COM_DATALEN] ? {1'b1, {(COM_DATALEN-1){1'b0}}}
                                         : {1'b0, {(COM_DATALEN-1){1'b1}}};
      end else begin
        acc_d[e] = sum_d[e][COM_DATALEN-1:0];
      end
    end
  end

  // Accumulators, then pairwise max, then final max; stages hold between updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      s1_quad_q <= '0;
      s1_max_q  <= '0;
      quad_q    <= '0;
      pool_q    <= '0;
    end else begin
      if (acc_en) begin
        acc_q <= acc_d;
      end
      if (s1_en) begin
        s1_quad_q   <= acc_q;
        s1_max_q[0] <= smax(acc_q[0], acc_q[1]);
        s1_max_q[1] <= smax(acc_q[2], acc_q[3]);
      end
      if (s2_en) begin
        quad_q <= s1_quad_q;
        pool_q <= smax(s1_max_q[0], s1_max_q[1]);
      end
    end
  end

  assign quad = quad_q;
  assign pool = pool_q;

endmodule

// File: rtl/psum_pool_collect.sv
// Collects MAC-mesh partial-sum quads over channel-group beats and emits quads plus 2x2 maxima.
module psum_pool_collect
  import psum_pool_collect_pkg::*;
#(
  parameter int unsigned X_MESH       = 16,
  parameter int unsigned PSUM_LEN     = PSUM_LEN_DEF,
  parameter int unsigned COM_DATALEN  = COM_DATALEN_DEF,
  parameter int unsigned ACC_CNT_LEN  = 8,
  parameter int unsigned QUAD_CNT_LEN = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              conf_input,
  input  logic [ACC_CNT_LEN-1:0]            acc_num,
  input  logic [QUAD_CNT_LEN-1:0]           quad_num,
  input  logic                              mac_valid,
  input  logic [4*PSUM_LEN*X_MESH-1:0]      psum_in,
  output logic [4*COM_DATALEN*X_MESH-1:0]   data_4,
  output logic [COM_DATALEN*X_MESH-1:0]     data_1,
  output logic                              dvalid,
  output logic                              indata_valid,
  output logic                              busy,
  output logic                              err_drop
);

  localparam logic [ACC_CNT_LEN-1:0]  AccOne  = ACC_CNT_LEN'(1);
  localparam logic [QUAD_CNT_LEN-1:0] QuadOne = QUAD_CNT_LEN'(1);

  state_t                  state_q;
  logic [ACC_CNT_LEN-1:0]  acc_num_q;
  logic [ACC_CNT_LEN-1:0]  beat_cnt_q;
  logic [QUAD_CNT_LEN-1:0] quad_num_q;
  logic [QUAD_CNT_LEN-1:0] quad_cnt_q;
  logic                    drain_cnt_q;
  logic                    err_drop_q;
  logic                    s0_valid_q, s0_first_q;
  logic                    s1_valid_q, s1_first_q;
  logic                    dvalid_q, indata_valid_q;

  logic beat, last_beat, last_quad, acc_load;

  assign beat      = (state_q == ST_ACC) && mac_valid;
  assign last_beat = (beat_cnt_q == acc_num_q - AccOne);
  assign last_quad = (quad_cnt_q == quad_num_q - QuadOne);
  assign acc_load  = (beat_cnt_q == '0);

  // Job FSM: config latch, beat/quad counting, drain, sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_num_q   <= '0;
      beat_cnt_q  <= '0;
      quad_num_q  <= '0;
      quad_cnt_q  <= '0;
      drain_cnt_q <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      if ((mac_valid && state_q != ST_ACC) || (conf_input && state_q != ST_IDLE)) begin
        err_drop_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (conf_input && quad_num != '0) begin
            acc_num_q  <= (acc_num == '0) ? AccOne : acc_num;
            quad_num_q <= quad_num;
            beat_cnt_q <= '0;
            quad_cnt_q <= '0;
            state_q    <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (mac_valid) begin
            if (last_beat) begin
              beat_cnt_q <= '0;
              if (last_quad) begin
                state_q     <= ST_DRAIN;
                drain_cnt_q <= 1'b0;
              end else begin
                quad_cnt_q <= quad_cnt_q + QuadOne;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + AccOne;
            end
          end
        end
        ST_DRAIN: begin
          // Two cycles covers the two pipeline stages behind the accumulator.
          if (drain_cnt_q) begin
            state_q <= ST_IDLE;
          end
          drain_cnt_q <= ~drain_cnt_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stage valids and first-quad tag travel alongside the lane pipelines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q     <= 1'b0;
      s0_first_q     <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_first_q     <= 1'b0;
      dvalid_q       <= 1'b0;
      indata_valid_q <= 1'b0;
    end else begin
      s0_valid_q     <= beat && last_beat;
      s0_first_q     <= (quad_cnt_q == '0);
      s1_valid_q     <= s0_valid_q;
      s1_first_q     <= s0_first_q;
      dvalid_q       <= s1_valid_q;
      indata_valid_q <= s1_valid_q && s1_first_q;
    end
  end

  for (genvar i = 0; i < X_MESH; i++) begin : g_lane
    psum_lane #(
      .PSUM_LEN    (PSUM_LEN),
      .COM_DATALEN (COM_DATALEN)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .acc_en   (beat),
      .acc_load (acc_load),
      .s1_en    (s0_valid_q),
      .s2_en    (s1_valid_q),
      .psum     (psum_in[i*4*PSUM_LEN +: 4*PSUM_LEN]),
      .quad     (data_4[i*4*COM_DATALEN +: 4*COM_DATALEN]),
      .pool     (data_1[i*COM_DATALEN +: COM_DATALEN])
    );
  end

  assign dvalid       = dvalid_q;
  assign indata_valid = indata_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign err_drop     = err_drop_q;

endmodule

// File: tb/tb_psum_pool_collect.sv
// Randomized bench for psum_pool_collect with a quad-level reference model.
module tb_psum_pool_collect;

  localparam int XM = 16;
  localparam int PL = 20;
  localparam int CL = 24;
  localparam int AL = 8;
  localparam int QL = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            conf_input = 1'b0;
  logic [AL-1:0]   acc_num = '0;
  logic [QL-1:0]   quad_num = '0;
  logic            mac_valid = 1'b0;
  logic [4*PL*XM-1:0] psum_in = '0;
  logic [4*CL*XM-1:0] data_4;
  logic [CL*XM-1:0]   data_1;
  logic            dvalid, indata_valid, busy, err_drop;

  typedef struct {
    logic [4*CL*XM-1:0] d4;
    logic [CL*XM-1:0]   d1;
    logic               first;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;
  logic exp_dv;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  psum_pool_collect u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .conf_input   (conf_input),
    .acc_num      (acc_num),
    .quad_num     (quad_num),
    .mac_valid    (mac_valid),
    .psum_in      (psum_in),
    .data_4       (data_4),
    .data_1       (data_1),
    .dvalid       (dvalid),
    .indata_valid (indata_valid),
    .busy         (busy),
    .err_drop     (err_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint clamp(input longint x);
    if (x > 64'sd8388607) return 64'sd8388607;
    if (x < -64'sd8388608) return -64'sd8388608;
    return x;
  endfunction

  function automatic longint beat_val(input int mode, input int q, input int b,
                                      input int i, input int e);
    logic [PL-1:0] r;
    int t1 [4][4];
    int t2 [3];
    t1 = '{'{1, 2, 3, 4}, '{-5, -6, -7, -8}, '{0, 0, 0, 0}, '{7, -1, 7, 2}};
    t2 = '{100, 200, -50};
    r = PL'($urandom());
    case (mode)
      1:       return (i == 0) ? longint'(t1[q][e]) : longint'($signed(r));
      2:       return longint'(t2[b]);
      3:       return 64'sd524287;
      4:       return -64'sd524288;
      default: return longint'($signed(r));
    endcase
  endfunction

  // Output monitor: every cycle, dvalid must match the model's schedule.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      exp_dv = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      check("dvalid", dvalid, exp_dv);
      if (exp_dv) begin
        e_cur = exp_q.pop_front();
        check("indata_valid", indata_valid, e_cur.first);
        for (int i = 0; i < XM; i++) begin
          check($sformatf("data_4_lane%0d", i), data_4[i*4*CL +: 4*CL], e_cur.d4[i*4*CL +: 4*CL]);
          check($sformatf("data_1_lane%0d", i), data_1[i*CL +: CL], e_cur.d1[i*CL +: CL]);
        end
      end else begin
        check("indata_valid_idle", indata_valid, 1'b0);
      end
    end
  end

  // Drive one job; the model sums each quad by the accumulate rules and schedules its pulse.
  task automatic run_job(input int an, input int qn, input int mode, input int gap_pct,
                         input int max_beats, input bit poke);
    int     ae;
    int     nb;
    longint s [XM][4];
    longint v;
    longint mx;
    exp_t   rec;
    ae = (an == 0) ? 1 : an;
    acc_num    = AL'(an);
    quad_num   = QL'(qn);
    conf_input = 1'b1;
    @(posedge clk); #1;
    conf_input = 1'b0;
    nb = 0;
    for (int q = 0; q < qn; q++) begin
      for (int b = 0; b < ae; b++) begin
        if (max_beats >= 0 && nb >= max_beats) begin
          mac_valid = 1'b0;
          return;
        end
        if (int'($urandom_range(99)) < gap_pct) begin
          mac_valid = 1'b0;
          repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < XM; i++) begin
          for (int e = 0; e < 4; e++) begin
            v = beat_val(mode, q, b, i, e);
            psum_in[(i*4+e)*PL +: PL] = PL'(v);
            s[i][e] = (b == 0) ? v : clamp(s[i][e] + v);
          end
        end
        if (poke && q == 1 && b == 0) begin
          conf_input = 1'b1;
          acc_num    = AL'(5);
          quad_num   = QL'(7);
        end
        mac_valid = 1'b1;
        @(posedge clk); #1;
        conf_input = 1'b0;
        nb++;
        if (q == 0 && b == 0) check("busy_running", busy, 1'b1);
        if (b == ae - 1) begin
          for (int i = 0; i < XM; i++) begin
            mx = s[i][0];
            for (int e = 0; e < 4; e++) begin
              rec.d4[(i*4+e)*CL +: CL] = CL'(s[i][e]);
              if (s[i][e] > mx) mx = s[i][e];
            end
            rec.d1[i*CL +: CL] = CL'(mx);
          end
          rec.first = (q == 0);
          rec.cyc   = cyc + 2;
          exp_q.push_back(rec);
        end
      end
    end
    mac_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin @(posedge clk); #1; end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk); #1;
    check("busy_after_job", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_dvalid", dvalid, 1'b0);
    check("rst_indata_valid", indata_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_drop", err_drop, 1'b0);
    check("rst_data_1", |data_1, 1'b0);
    check("rst_data_4", |data_4, 1'b0);

    // quad_num == 0 start is ignored silently
    acc_num = AL'(1); quad_num = '0; conf_input = 1'b1;
    @(posedge clk); #1;
    conf_input = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("qn0_busy", busy, 1'b0);
    check("qn0_err", err_drop, 1'b0);

    // Directed lane-0 quads, back-to-back
    run_job(1, 4, 1, 0, -1, 1'b0);
    // Three beats with gaps
    run_job(3, 1, 2, 100, -1, 1'b0);
    // Saturation: no overflow at acc_num=2, then positive and negative clamps
    run_job(2, 40, 3, 0, -1, 1'b0);
    run_job(32, 1, 3, 0, -1, 1'b0);
    run_job(40, 1, 3, 0, -1, 1'b0);
    run_job(32, 1, 4, 0, -1, 1'b0);
    check("err_clean", err_drop, 1'b0);

    // Random jobs, including acc_num == 0
    repeat (6) run_job($urandom_range(0, 4), $urandom_range(1, 6), 0, 30, -1, 1'b0);
    check("err_clean_rand", err_drop, 1'b0);

    // Beat while idle is dropped
    for (int i = 0; i < XM * 4; i++) psum_in[i*PL +: PL] = PL'($urandom());
    mac_valid = 1'b1;
    @(posedge clk); #1;
    mac_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("idle_beat_err", err_drop, 1'b1);
    check("idle_beat_busy", busy, 1'b0);
    // Config strobe mid-job is ignored
    run_job(1, 3, 0, 0, -1, 1'b1);
    check("busy_conf_err", err_drop, 1'b1);

    // Reset during quad 2 of 5
    run_job(2, 5, 0, 0, 5, 1'b0);
    exp_q.delete();
    rst_n = 1'b0;
    #2;
    check("midrst_dvalid", dvalid, 1'b0);
    check("midrst_indata_valid", indata_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_err", err_drop, 1'b0);
    check("midrst_data_1", |data_1, 1'b0);
    check("midrst_data_4", |data_4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("postrst_busy", busy, 1'b0);
    run_job(2, 3, 0, 20, -1, 1'b0);
    run_job(1, 5, 0, 0, -1, 1'b0);

    repeat (3) begin @(posedge clk); #1; end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
